// File: rtl/imem_arbiter.sv
// imem_arbiter: shares one combinational instruction ROM between the fetch
// stage and the decompressor. Fetch has priority. A starve counter forces a
// decompressor grant after STARVE_LIMIT consecutive denials. Responses are
// registered one cycle after the grant. Out-of-range addresses never reach the
// ROM and return zero data with addr_err.
module imem_arbiter #(
    parameter int DEPTH        = 400,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        f_req,
    input  logic [31:0] f_addr,
    output logic        f_gnt,
    output logic        f_rvalid,
    output logic [31:0] f_rdata,

    input  logic        d_req,
    input  logic [31:0] d_addr,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,

    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    output logic        addr_err
);

    // The counter must be able to hold STARVE_LIMIT.
    // Keep it at least one bit wide so a zero limit still elaborates.
    localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIMIT   = SW'(STARVE_LIMIT);
    localparam logic [31:0]   DEPTH_W = 32'(DEPTH);

    // Requester index 0 is fetch and index 1 is the decompressor.
    logic [1:0]  w_req;
    logic [1:0]  w_gnt;
    logic [1:0]  w_in_range;
    logic        w_force;
    logic [31:0] w_mem_addr;
    logic [SW-1:0] r_starve;
    logic        r_addr_err;

    assign w_req = {d_req, f_req};

    // Range check for both requesters. It is used to gate the ROM address
    // and to flag the response.
    always_comb begin
        w_in_range    = '0;
        w_in_range[0] = (f_addr < DEPTH_W);
        w_in_range[1] = (d_addr < DEPTH_W);
    end

    // Priority arbitration. Fetch normally wins. A decompressor that has
    // been denied STARVE_LIMIT cycles in a row takes the port. The force only
    // matters while d_req is up; otherwise an idle decompressor would block
    // fetch for no benefit. No grants while in reset.
    always_comb begin
        w_force = (r_starve == LIMIT);
        w_gnt   = '0;
        if (!rst) begin
            if (w_req[1] && (!w_req[0] || w_force)) begin
                w_gnt[1] = 1'b1;
            end else if (w_req[0]) begin
                w_gnt[0] = 1'b1;
            end
        end
    end

    // ROM address mux. The output is zero when idle, and zero when the
    // granted address is outside the ROM so the ROM never sees it.
    always_comb begin
        w_mem_addr = 32'd0;
        if (w_gnt[0] && w_in_range[0]) begin
            w_mem_addr = f_addr;
        end else if (w_gnt[1] && w_in_range[1]) begin
            w_mem_addr = d_addr;
        end
    end

    // Starve counter. It counts consecutive denied decompressor requests and
    // saturates at the limit. It clears once the decompressor is served or
    // stops asking.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve <= '0;
        end else if (w_req[1] && !w_gnt[1]) begin
            if (r_starve != LIMIT) begin
                r_starve <= r_starve + 1'b1;
            end
        end else begin
            r_starve <= '0;
        end
    end

    // One response slice per requester. Each slice pulses rvalid the cycle
    // after its grant and holds the last captured data between pulses.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_resp
            logic        r_rvalid;
            logic [31:0] r_rdata;

            // Capture the ROM word for this requester, or zero if it is out of range.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_rvalid <= 1'b0;
                    r_rdata  <= 32'd0;
                end else begin
                    r_rvalid <= w_gnt[gi];
                    if (w_gnt[gi]) begin
                        r_rdata <= w_in_range[gi] ? mem_rdata : 32'd0;
                    end
                end
            end
        end
    endgenerate

    // The error flag follows the single response issued this cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr_err <= 1'b0;
        end else begin
            r_addr_err <= |(w_gnt & ~w_in_range);
        end
    end

    assign f_gnt    = w_gnt[0];
    assign d_gnt    = w_gnt[1];
    assign mem_addr = w_mem_addr;

    // Response outputs are masked while rst is high. A grant issued in the
    // cycle just before reset therefore never surfaces, even before the
    // clearing edge arrives.
    assign f_rvalid = g_resp[0].r_rvalid & ~rst;
    assign d_rvalid = g_resp[1].r_rvalid & ~rst;
    assign f_rdata  = rst ? 32'd0 : g_resp[0].r_rdata;
    assign d_rdata  = rst ? 32'd0 : g_resp[1].r_rdata;
    assign addr_err = r_addr_err & ~rst;

endmodule

// File: tb/tb_imem_arbiter.sv
// Bench for imem_arbiter: directed scenarios plus randomized traffic checked
// against a transaction-level model of the arbitration and response rules.
module tb_imem_arbiter;

    localparam int TB_DEPTH = 400;
    localparam int TB_LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        f_req = 1'b0;
    logic [31:0] f_addr = '0;
    logic        f_gnt, f_rvalid;
    logic [31:0] f_rdata;
    logic        d_req = 1'b0;
    logic [31:0] d_addr = '0;
    logic        d_gnt, d_rvalid;
    logic [31:0] d_rdata;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        addr_err;

    int total = 0;
    int bad   = 0;

    logic [31:0] rom [0:511];

    // Model state: the denial streak, the response owed from the last grant,
    // and the last data each requester received.
    int          m_cnt;
    bit          m_pf, m_pd, m_perr;
    logic [31:0] m_fhold, m_dhold;

    // Expected values for the cycle that is currently applied.
    bit          e_fg, e_dg, e_fv, e_dv, e_err;
    logic [31:0] e_maddr, e_frd, e_drd;

    imem_arbiter #(.DEPTH(TB_DEPTH), .STARVE_LIMIT(TB_LIMIT)) dut (
        .clk(clk), .rst(rst),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
        .d_req(d_req), .d_addr(d_addr), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_addr(mem_addr), .mem_rdata(mem_rdata), .addr_err(addr_err)
    );

    always #5 clk = ~clk;

    // Combinational ROM model.
    always_comb begin
        mem_rdata = 32'h0;
        if (mem_addr < 32'(TB_DEPTH)) mem_rdata = rom[mem_addr[8:0]];
    end

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        if (a < 32'(TB_DEPTH)) return rom[a[8:0]];
        return 32'h0;
    endfunction

    // Drive one cycle of inputs and compute what the outputs must show.
    // Then advance the model across the next rising edge.
    task automatic apply(input bit r, input bit fr, input logic [31:0] fa,
                         input bit dr, input logic [31:0] da);
        logic [31:0] ga;
        @(posedge clk);
        #1;
        rst = r; f_req = fr; f_addr = fa; d_req = dr; d_addr = da;
        #3;
        if (r) begin
            e_fg = 0; e_dg = 0; e_maddr = 0; e_fv = 0; e_dv = 0; e_err = 0;
            e_frd = 0; e_drd = 0;
            m_cnt = 0; m_pf = 0; m_pd = 0; m_perr = 0; m_fhold = 0; m_dhold = 0;
        end else begin
            e_dg = dr && (!fr || m_cnt == TB_LIMIT);
            e_fg = fr && !e_dg;
            ga   = e_fg ? fa : da;
            e_maddr = ((e_fg || e_dg) && ga < 32'(TB_DEPTH)) ? ga : 32'h0;
            e_fv = m_pf; e_dv = m_pd; e_err = m_perr;
            e_frd = m_fhold; e_drd = m_dhold;
            if (dr && !e_dg) m_cnt = (m_cnt + 1 > TB_LIMIT) ? TB_LIMIT : m_cnt + 1;
            else             m_cnt = 0;
            m_pf = e_fg; m_pd = e_dg;
            m_perr = (e_fg || e_dg) && !(ga < 32'(TB_DEPTH));
            if (e_fg) m_fhold = rom_word(fa);
            if (e_dg) m_dhold = rom_word(da);
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            apply(1, 1, 32'd3, 1, 32'd4);
            total++; if (f_gnt !== 1'b0) begin bad++; $display("FAIL reset_f_gnt got=%0b want=0", f_gnt); end
            total++; if (d_gnt !== 1'b0) begin bad++; $display("FAIL reset_d_gnt got=%0b want=0", d_gnt); end
            total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL reset_mem_addr got=%0h want=0", mem_addr); end
            total++; if ({f_rvalid, d_rvalid, addr_err} !== 3'b000) begin bad++; $display("FAIL reset_valids got=%b want=000", {f_rvalid, d_rvalid, addr_err}); end
            total++; if (f_rdata !== 32'h0 || d_rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h/%h want=0/0", f_rdata, d_rdata); end
        end
        apply(0, 0, 0, 0, 0);
        total++; if ({f_rvalid, d_rvalid, addr_err} !== 3'b000) begin bad++; $display("FAIL reset_release_valids got=%b want=000", {f_rvalid, d_rvalid, addr_err}); end
        $display("test_reset checked");
    endtask

    task automatic test_fetch_only();
        apply(0, 1, 32'd5, 0, 0);
        total++; if (f_gnt !== 1'b1 || d_gnt !== 1'b0) begin bad++; $display("FAIL fetch_gnt got=%b%b want=10", f_gnt, d_gnt); end
        total++; if (mem_addr !== 32'd5) begin bad++; $display("FAIL fetch_mem_addr got=%0d want=5", mem_addr); end
        apply(0, 0, 0, 0, 0);
        total++; if (f_rvalid !== 1'b1 || d_rvalid !== 1'b0) begin bad++; $display("FAIL fetch_rvalid got=%b%b want=10", f_rvalid, d_rvalid); end
        total++; if (f_rdata !== 32'hE3A01001) begin bad++; $display("FAIL fetch_rdata got=%h want=e3a01001", f_rdata); end
        total++; if (addr_err !== 1'b0) begin bad++; $display("FAIL fetch_addr_err got=%b want=0", addr_err); end
        $display("test_fetch_only checked");
    endtask

    task automatic test_contention();
        bit want_d;
        for (int i = 0; i < 15; i++) begin
            apply(0, 1, 32'($urandom_range(0, TB_DEPTH - 1)), 1, 32'($urandom_range(0, TB_DEPTH - 1)));
            want_d = (i % 5 == 4);
            total++; if (d_gnt !== want_d || f_gnt !== !want_d) begin bad++; $display("FAIL contention_gnt cycle=%0d got=%b%b want=%b%b", i, f_gnt, d_gnt, !want_d, want_d); end
        end
        apply(0, 0, 0, 0, 0);
        $display("test_contention checked");
    endtask

    task automatic test_alternating();
        apply(0, 1, 32'd1, 0, 0);
        total++; if (f_gnt !== 1'b1 || mem_addr !== 32'd1) begin bad++; $display("FAIL alt_g1 got=%b addr=%0d want=1 addr=1", f_gnt, mem_addr); end
        apply(0, 0, 0, 1, 32'd2);
        total++; if (d_gnt !== 1'b1 || mem_addr !== 32'd2) begin bad++; $display("FAIL alt_g2 got=%b addr=%0d want=1 addr=2", d_gnt, mem_addr); end
        total++; if (f_rvalid !== 1'b1 || d_rvalid !== 1'b0 || f_rdata !== rom[1]) begin bad++; $display("FAIL alt_r1 got=%b%b %h want=10 %h", f_rvalid, d_rvalid, f_rdata, rom[1]); end
        apply(0, 1, 32'd3, 0, 0);
        total++; if (f_gnt !== 1'b1 || mem_addr !== 32'd3) begin bad++; $display("FAIL alt_g3 got=%b addr=%0d want=1 addr=3", f_gnt, mem_addr); end
        total++; if (d_rvalid !== 1'b1 || f_rvalid !== 1'b0 || d_rdata !== rom[2]) begin bad++; $display("FAIL alt_r2 got=%b%b %h want=01 %h", f_rvalid, d_rvalid, d_rdata, rom[2]); end
        apply(0, 0, 0, 1, 32'd4);
        total++; if (d_gnt !== 1'b1 || mem_addr !== 32'd4) begin bad++; $display("FAIL alt_g4 got=%b addr=%0d want=1 addr=4", d_gnt, mem_addr); end
        total++; if (f_rvalid !== 1'b1 || d_rvalid !== 1'b0 || f_rdata !== rom[3]) begin bad++; $display("FAIL alt_r3 got=%b%b %h want=10 %h", f_rvalid, d_rvalid, f_rdata, rom[3]); end
        apply(0, 0, 0, 0, 0);
        total++; if (d_rvalid !== 1'b1 || f_rvalid !== 1'b0 || d_rdata !== rom[4]) begin bad++; $display("FAIL alt_r4 got=%b%b %h want=01 %h", f_rvalid, d_rvalid, d_rdata, rom[4]); end
        $display("test_alternating checked");
    endtask

    task automatic test_out_of_range();
        apply(0, 0, 0, 1, 32'd400);
        total++; if (d_gnt !== 1'b1 || mem_addr !== 32'h0) begin bad++; $display("FAIL oor_gnt got=%b addr=%0d want=1 addr=0", d_gnt, mem_addr); end
        apply(0, 1, 32'd399, 0, 0);
        total++; if (d_rvalid !== 1'b1 || d_rdata !== 32'h0 || addr_err !== 1'b1) begin bad++; $display("FAIL oor_resp got=%b %h err=%b want=1 0 err=1", d_rvalid, d_rdata, addr_err); end
        total++; if (f_gnt !== 1'b1 || mem_addr !== 32'd399) begin bad++; $display("FAIL edge_gnt got=%b addr=%0d want=1 addr=399", f_gnt, mem_addr); end
        apply(0, 1, 32'hFFFF_FFFF, 0, 0);
        total++; if (f_rvalid !== 1'b1 || f_rdata !== rom[399] || addr_err !== 1'b0) begin bad++; $display("FAIL edge_resp got=%b %h err=%b want=1 %h err=0", f_rvalid, f_rdata, addr_err, rom[399]); end
        total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL big_mem_addr got=%h want=0", mem_addr); end
        apply(0, 0, 0, 0, 0);
        total++; if (f_rvalid !== 1'b1 || f_rdata !== 32'h0 || addr_err !== 1'b1) begin bad++; $display("FAIL big_resp got=%b %h err=%b want=1 0 err=1", f_rvalid, f_rdata, addr_err); end
        apply(0, 0, 0, 0, 0);
        total++; if (addr_err !== 1'b0 || f_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin bad++; $display("FAIL oor_idle got=%b%b err=%b want=00 err=0", f_rvalid, d_rvalid, addr_err); end
        $display("test_out_of_range checked");
    endtask

    task automatic test_reset_mid();
        bit want_d;
        apply(0, 1, 32'd10, 1, 32'd11);
        apply(0, 1, 32'd12, 1, 32'd11);
        apply(0, 1, 32'd7, 1, 32'd11);
        total++; if (f_gnt !== 1'b1) begin bad++; $display("FAIL rmid_grant got=%b want=1", f_gnt); end
        apply(1, 1, 32'd8, 1, 32'd9);
        total++; if ({f_rvalid, d_rvalid, addr_err, f_gnt, d_gnt} !== 5'b0) begin bad++; $display("FAIL rmid_n1 got=%b want=00000", {f_rvalid, d_rvalid, addr_err, f_gnt, d_gnt}); end
        total++; if (mem_addr !== 32'h0 || f_rdata !== 32'h0 || d_rdata !== 32'h0) begin bad++; $display("FAIL rmid_n1_data got=%h %h %h want=0 0 0", mem_addr, f_rdata, d_rdata); end
        for (int i = 0; i < 5; i++) begin
            apply(0, 1, 32'd8, 1, 32'd9);
            if (i == 0) begin
                total++; if (f_rvalid !== 1'b0 || d_rvalid !== 1'b0 || f_rdata !== 32'h0) begin bad++; $display("FAIL rmid_n2 got=%b%b %h want=00 0", f_rvalid, d_rvalid, f_rdata); end
            end
            want_d = (i == 4);
            total++; if (d_gnt !== want_d || f_gnt !== !want_d) begin bad++; $display("FAIL rmid_counter cycle=%0d got=%b%b want=%b%b", i, f_gnt, d_gnt, !want_d, want_d); end
        end
        apply(0, 0, 0, 0, 0);
        $display("test_reset_mid checked");
    endtask

    task automatic test_drop();
        bit want_d;
        apply(0, 1, 32'd20, 1, 32'd21);
        total++; if (d_gnt !== 1'b0 || f_gnt !== 1'b1) begin bad++; $display("FAIL drop_gnt got=%b%b want=10", f_gnt, d_gnt); end
        for (int i = 0; i < 4; i++) begin
            apply(0, 1, 32'(21 + i), 0, 0);
            total++; if (d_rvalid !== 1'b0 || d_gnt !== 1'b0) begin bad++; $display("FAIL drop_no_resp cycle=%0d got=%b%b want=00", i, d_rvalid, d_gnt); end
        end
        for (int i = 0; i < 5; i++) begin
            apply(0, 1, 32'd30, 1, 32'd31);
            want_d = (i == 4);
            total++; if (d_gnt !== want_d) begin bad++; $display("FAIL drop_counter cycle=%0d got=%b want=%b", i, d_gnt, want_d); end
        end
        apply(0, 0, 0, 0, 0);
        $display("test_drop checked");
    endtask

    task automatic test_random();
        bit r, fr, dr;
        logic [31:0] fa, da;
        for (int i = 0; i < 800; i++) begin
            r  = ($urandom_range(0, 39) == 0);
            fr = ($urandom_range(0, 3) != 0);
            dr = ($urandom_range(0, 2) != 0);
            fa = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(400, 2000)) : 32'($urandom_range(0, 399));
            da = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 399));
            apply(r, fr, fa, dr, da);
            total++; if (f_gnt !== e_fg || d_gnt !== e_dg) begin bad++; $display("FAIL rnd_gnt cycle=%0d got=%b%b want=%b%b", i, f_gnt, d_gnt, e_fg, e_dg); end
            total++; if (mem_addr !== e_maddr) begin bad++; $display("FAIL rnd_mem_addr cycle=%0d got=%h want=%h", i, mem_addr, e_maddr); end
            total++; if (f_rvalid !== e_fv || d_rvalid !== e_dv || addr_err !== e_err) begin bad++; $display("FAIL rnd_valid cycle=%0d got=%b%b%b want=%b%b%b", i, f_rvalid, d_rvalid, addr_err, e_fv, e_dv, e_err); end
            total++; if (f_rdata !== e_frd) begin bad++; $display("FAIL rnd_f_rdata cycle=%0d got=%h want=%h", i, f_rdata, e_frd); end
            total++; if (d_rdata !== e_drd) begin bad++; $display("FAIL rnd_d_rdata cycle=%0d got=%h want=%h", i, d_rdata, e_drd); end
        end
        $display("test_random checked");
    endtask

    initial begin
        for (int i = 0; i < 512; i++) rom[i] = $urandom;
        rom[5] = 32'hE3A01001;
        m_cnt = 0; m_pf = 0; m_pd = 0; m_perr = 0; m_fhold = 0; m_dhold = 0;
        test_reset();
        test_fetch_only();
        test_contention();
        test_alternating();
        test_out_of_range();
        test_reset_mid();
        test_drop();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/imem_arbiter.md
IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 400: number of 32-bit words in the instruction ROM; valid word addresses are 0..DEPTH-1.
REQ-002 SHALL have parameter STARVE_LIMIT, default 4: consecutive denied decompressor cycles before the decompressor is forced a grant.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port f_req, input, 1 bit: fetch-stage read request.
REQ-006 SHALL have port f_addr, input, 32 bits: fetch word address (pc).
REQ-007 SHALL have port f_gnt, output, 1 bit: fetch request accepted this cycle.
REQ-008 SHALL have port f_rvalid, output, 1 bit: fetch read data valid.
REQ-009 SHALL have port f_rdata, output, 32 bits: fetch read data.
REQ-010 SHALL have port d_req, input, 1 bit: decompressor read request.
REQ-011 SHALL have port d_addr, input, 32 bits: decompressor word address.
REQ-012 SHALL have port d_gnt, output, 1 bit: decompressor request accepted this cycle.
REQ-013 SHALL have port d_rvalid, output, 1 bit: decompressor read data valid.
REQ-014 SHALL have port d_rdata, output, 32 bits: decompressor read data.
REQ-015 SHALL have port mem_addr, output, 32 bits: address to the instruction ROM's pc input.
REQ-016 SHALL have port mem_rdata, input, 32 bits: combinational data from the instruction ROM.
REQ-017 SHALL have port addr_err, output, 1 bit: the response presented this cycle was for an out-of-range address.

Function
REQ-018 SHALL assert at most one of f_gnt and d_gnt in any cycle; each is combinational from the requests and the registered arbitration state.
REQ-019 SHALL grant fetch when f_req=1, unless the forced-grant condition (REQ-021) holds.
REQ-020 SHALL grant the decompressor when d_req=1 and either f_req=0 or the forced-grant condition holds.
REQ-021 SHALL keep a starve counter, width ceil(log2(STARVE_LIMIT+1)):
- increments when d_req=1 and d_gnt=0;
- clears when d_gnt=1 or d_req=0;
- forced-grant condition is counter == STARVE_LIMIT;
- saturates at STARVE_LIMIT.
REQ-022 SHALL drive mem_addr = address of the granted requester, and 0 when neither is granted.
REQ-023 SHALL register the response one cycle after grant:
- capture mem_rdata into the granted side's rdata;
- pulse that side's rvalid for exactly one cycle;
- assert no rvalid in cycles following no grant.
REQ-024 SHALL hold f_rdata/d_rdata at their last captured value when the corresponding rvalid is 0.
REQ-025 SHALL, for a granted address >= DEPTH:
- not drive that address to mem_addr (drive 0 instead);
- return rdata = 0x00000000 with rvalid=1 and addr_err=1 in the response cycle.
REQ-026 SHALL assert addr_err only coincident with an rvalid pulse.
REQ-027 SHALL accept back-to-back grants every cycle (throughput one read/cycle), including alternating requesters, with responses in grant order.
REQ-028 SHALL NOT require requests to be held after grant; a request deasserted without grant is dropped with no response.

Reset
REQ-029 SHALL, while rst=1 at a rising clk edge, clear the starve counter, f_rvalid, d_rvalid, addr_err, f_rdata and d_rdata to 0.
REQ-030 SHALL force f_gnt=0, d_gnt=0 and mem_addr=0 combinationally while rst=1.
REQ-031 SHALL discard any response pending from a grant in the cycle before reset asserts; no rvalid in the first cycle after rst deasserts.

Verification
REQ-032 SHALL cover fetch only: f_req=1, f_addr=5, ROM[5]=0xE3A01001 -> f_gnt=1, mem_addr=5 in cycle N; f_rvalid=1, f_rdata=0xE3A01001 in N+1.
REQ-033 SHALL cover contention: f_req=d_req=1 continuously, STARVE_LIMIT=4 -> f_gnt for 4 cycles, d_gnt on the 5th, then pattern repeats; never both grants.
REQ-034 SHALL cover alternating back-to-back requests: grant pattern F,D,F,D at addresses 1,2,3,4 -> rvalids F,D,F,D each one cycle later with ROM[1..4].
REQ-035 SHALL cover out of range: d_addr=400, d_req=1, f_req=0 -> d_gnt=1, mem_addr=0; next cycle d_rvalid=1, d_rdata=0, addr_err=1.
REQ-036 SHALL cover reset mid-operation: grant at cycle N, rst=1 at N+1 -> no rvalid at N+1 or N+2, counter=0, all outputs 0.
REQ-037 SHALL cover drop: d_req pulsed one cycle while f_req=1 -> d_gnt never asserted, no d_rvalid, counter returns to 0.
